alu_seq_ctrl: RTL and testbench

- Multi-cycle controller that drives the 4-bit combinational ALU from the requesting side.
- Accepts 8-bit register-register instructions over a valid/ready handshake and reads two operands from an internal 4x4-bit register file.
- Presents A/B/ALUop to the ALU, captures C, and writes the result back.
- Sits between the instruction source and the existing ALU, owning operand storage and sequencing.

---
 rtl/alu_seq_ctrl_pkg.sv | 26 ++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_seq_ctrl.sv | 110 +++++++++++
 tb/tb_alu_seq_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the ALU sequencing controller:
// opcodes, instruction field positions and FSM state encoding.
package alu_seq_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RD_MSB = 5;
    localparam int RD_LSB = 4;
    localparam int RS_MSB = 3;
    localparam int RS_LSB = 2;
    localparam int RT_MSB = 1;
    localparam int RT_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small operand register file: two operand read ports, one debug
// read port and a single synchronous write port.
module alu_regfile #(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] rs_addr,
    output logic [DATA_W-1:0] rs_data,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [DATA_W-1:0] rt_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [2**REG_AW];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rs_data  = regs[rs_addr];
    assign rt_data  = regs[rt_addr];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Four-state controller that feeds the combinational ALU from the
// register file and writes its result back.
module alu_seq_ctrl #(
    parameter int DATA_W = 4,
    parameter int REG_AW = 2,
    parameter int OP_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    input  logic [7:0]        instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_A,
    output logic [DATA_W-1:0] alu_B,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_C,
    output logic              done,
    output logic [DATA_W-1:0] result,
    input  logic              cfg_we,
    input  logic [REG_AW-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    import alu_seq_ctrl_pkg::*;

    state_t            state;
    logic [7:0]        ir;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    // Write-back owns the port in WB; preload only lands while idle.
    always_comb begin
        we    = 1'b0;
        waddr = cfg_addr;
        wdata = cfg_data;
        if (state == WB) begin
            we    = 1'b1;
            waddr = ir[RD_MSB:RD_LSB];
            wdata = result;
        end else if (state == IDLE) begin
            we    = cfg_we;
        end
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .rs_addr  (ir[RS_MSB:RS_LSB]),
        .rs_data  (rs_data),
        .rt_addr  (ir[RT_MSB:RT_LSB]),
        .rt_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ir          <= '0;
            instr_ready <= 1'b0;
            alu_A       <= '0;
            alu_B       <= '0;
            alu_op      <= '0;
            result      <= '0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    // First idle edge after reset only raises ready.
                    if (!instr_ready) begin
                        instr_ready <= 1'b1;
                    end else if (instr_valid) begin
                        ir          <= instr;
                        instr_ready <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    alu_A  <= rs_data;
                    alu_B  <= rt_data;
                    alu_op <= ir[OP_MSB:OP_LSB];
                    state  <= EXEC;
                end
                EXEC: begin
                    result <= alu_C;
                    done   <= 1'b1;
                    state  <= WB;
                end
                WB: begin
                    done        <= 1'b0;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 4-bit ALU
// attached to the controller's ALU-side ports.
module tb_alu_seq_ctrl;

    import alu_seq_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic [3:0] alu_A;
    logic [3:0] alu_B;
    logic [1:0] alu_op;
    logic [3:0] alu_C;
    logic       done;
    logic [3:0] result;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [3:0] cfg_data;
    logic [1:0] dbg_addr;
    logic [3:0] dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_A       (alu_A),
        .alu_B       (alu_B),
        .alu_op      (alu_op),
        .alu_C       (alu_C),
        .done        (done),
        .result      (result),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_C = '0;
        case (alu_op)
            OP_ADD:  alu_C = alu_A + alu_B;
            OP_SUB:  alu_C = alu_A - alu_B;
            OP_AND:  alu_C = alu_A & alu_B;
            default: alu_C = alu_A | alu_B;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] a, input logic [3:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a,
                             input logic [3:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {28'd0, dbg_data}, {28'd0, exp});
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!instr_ready && n < 10) begin
            tick();
            n++;
        end
        if (!instr_ready) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    // Issue one instruction, optionally with a coincident cfg write,
    // and follow it through READ, EXEC and WB.
    task automatic run(input string tag, input logic [1:0] op,
                       input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [3:0] ea,
                       input logic [3:0] eb, input logic [3:0] er,
                       input logic cw, input logic [1:0] ca,
                       input logic [3:0] cd);
        wait_ready(tag);
        instr       = {op, rd, rs, rt};
        instr_valid = 1'b1;
        cfg_we      = cw;
        cfg_addr    = ca;
        cfg_data    = cd;
        tick();
        instr_valid = 1'b0;
        cfg_we      = 1'b0;
        instr       = 8'hFF;
        check({tag, "_ready_read"}, {31'd0, instr_ready}, 0);
        tick();
        check({tag, "_A"}, {28'd0, alu_A}, {28'd0, ea});
        check({tag, "_B"}, {28'd0, alu_B}, {28'd0, eb});
        check({tag, "_op"}, {30'd0, alu_op}, {30'd0, op});
        check({tag, "_done_exec"}, {31'd0, done}, 0);
        tick();
        check({tag, "_done_wb"}, {31'd0, done}, 1);
        check({tag, "_result"}, {28'd0, result}, {28'd0, er});
        check({tag, "_ready_wb"}, {31'd0, instr_ready}, 0);
        tick();
        check({tag, "_done_after"}, {31'd0, done}, 0);
        check({tag, "_ready_after"}, {31'd0, instr_ready}, 1);
        check_reg({tag, "_rd"}, rd, er);
    endtask

    initial begin
        logic [7:0] q [3];
        logic [3:0] qexp [3];
        int idx, dcount, cyc;
        logic hs;

        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = '0;
        cfg_we      = 1'b0;
        cfg_addr    = '0;
        cfg_data    = '0;
        dbg_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, instr_ready}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_op", {30'd0, alu_op}, 0);
        check("rst_result", {28'd0, result}, 0);
        reset = 1'b0;
        #1;
        check("rel_ready_pre", {31'd0, instr_ready}, 0);
        tick();
        check("rel_ready_post", {31'd0, instr_ready}, 1);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 4'h0);

        // Add: r3 = 5 + 3
        preload(2'd1, 4'd5);
        preload(2'd2, 4'd3);
        run("add", OP_ADD, 2'd3, 2'd1, 2'd2, 4'd5, 4'd3, 4'd8,
            1'b0, 2'd0, 4'd0);

        // Sub wrap and add wrap
        preload(2'd1, 4'd2);
        preload(2'd2, 4'd3);
        run("sub_wrap", OP_SUB, 2'd0, 2'd1, 2'd2, 4'd2, 4'd3, 4'hF,
            1'b0, 2'd0, 4'd0);
        preload(2'd1, 4'd9);
        preload(2'd2, 4'd9);
        run("add_wrap", OP_ADD, 2'd1, 2'd1, 2'd2, 4'd9, 4'd9, 4'd2,
            1'b0, 2'd0, 4'd0);

        // Logic ops, rs==rt and rd overlapping a source
        preload(2'd1, 4'hC);
        preload(2'd2, 4'hA);
        run("and_same", OP_AND, 2'd1, 2'd1, 2'd1, 4'hC, 4'hC, 4'hC,
            1'b0, 2'd0, 4'd0);
        run("or_rd_rt", OP_OR, 2'd2, 2'd1, 2'd2, 4'hC, 4'hA, 4'hE,
            1'b0, 2'd0, 4'd0);

        // Regs now r0=F r1=C r2=E r3=8; valid held high for 3 instrs.
        q[0] = {OP_ADD, 2'd3, 2'd0, 2'd1};
        q[1] = {OP_SUB, 2'd0, 2'd3, 2'd2};
        q[2] = {OP_OR,  2'd1, 2'd0, 2'd3};
        qexp[0] = 4'hB;
        qexp[1] = 4'hD;
        qexp[2] = 4'hF;
        idx    = 0;
        dcount = 0;
        cyc    = -1;
        instr_valid = 1'b1;
        instr       = q[0];
        for (int c = 0; c < 20; c++) begin
            hs = instr_ready && instr_valid;
            tick();
            if (cyc >= 0) cyc++;
            if (hs) begin
                if (idx == 0) cyc = 0;
                idx++;
                if (idx < 3) instr = q[idx];
                else instr_valid = 1'b0;
            end
            if (cyc == 1) begin
                cfg_we   = 1'b1;
                cfg_addr = 2'd2;
                cfg_data = 4'h0;
            end else begin
                cfg_we = 1'b0;
            end
            if (done) begin
                if (dcount < 3)
                    check("b2b_result", {28'd0, result},
                          {28'd0, qexp[dcount]});
                dcount++;
            end
        end
        instr_valid = 1'b0;
        cfg_we      = 1'b0;
        check("b2b_done_count", dcount, 3);
        check_reg("b2b_r0", 2'd0, 4'hD);
        check_reg("b2b_r1", 2'd1, 4'hF);
        check_reg("b2b_r2_cfg_ignored", 2'd2, 4'hE);
        check_reg("b2b_r3", 2'd3, 4'hB);

        // cfg write coincident with handshake: r1 becomes 2 first
        run("cfg_coincide", OP_ADD, 2'd3, 2'd1, 2'd1, 4'd2, 4'd2,
            4'd4, 1'b1, 2'd1, 4'd2);

        // Reset during EXEC aborts the instruction
        wait_ready("abort");
        instr       = {OP_SUB, 2'd2, 2'd0, 2'd3};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        check("abort_exec_op", {30'd0, alu_op}, {30'd0, OP_SUB});
        reset = 1'b1;
        #1;
        check("abort_done", {31'd0, done}, 0);
        check("abort_A", {28'd0, alu_A}, 0);
        check("abort_op", {30'd0, alu_op}, 0);
        check("abort_ready", {31'd0, instr_ready}, 0);
        repeat (2) begin
            tick();
            check("abort_done_hold", {31'd0, done}, 0);
        end
        reset = 1'b0;
        tick();
        check("abort_ready_post", {31'd0, instr_ready}, 1);
        check_reg("abort_rd", 2'd2, 4'h0);
        check_reg("abort_r0", 2'd0, 4'h0);
        preload(2'd1, 4'd7);
        preload(2'd2, 4'd1);
        run("post_abort", OP_SUB, 2'd3, 2'd1, 2'd2, 4'd7, 4'd1, 4'd6,
            1'b0, 2'd0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
